// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipe_ctrl_pkg;

   localparam int REG_W = 5;

   // X31 is hardwired to zero, so writes to it can never create a hazard.
   localparam logic [REG_W-1:0] ZERO_REG = 5'd31;

   typedef enum logic {
      RUN      = 1'b0,
      MUL_WAIT = 1'b1
   } ctrl_state_t;

endpackage

// File: rtl/pipe_stall_ctrl_load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register that the ID instruction reads.
module load_use_detect
   import pipe_ctrl_pkg::*;
(
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] ex_rd,
   input  logic [REG_W-1:0] id_rs_a,
   input  logic [REG_W-1:0] id_rs_b,
   output logic             lu
);

   assign lu = ex_is_load && (ex_rd != ZERO_REG) &&
               ((ex_rd == id_rs_a) || (ex_rd == id_rs_b));

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: drives the bank enables and NOP inserts.
// Priority every cycle: mem_stall > multiply > load-use > taken branch.
module pipe_stall_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int MUL_CYCLES = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          mem_stall,
   input  logic                          mul_start,
   input  logic                          ex_is_load,
   input  logic [REG_W-1:0]              ex_rd,
   input  logic [REG_W-1:0]              id_rs_a,
   input  logic [REG_W-1:0]              id_rs_b,
   input  logic                          br_taken,
   output logic                          en_pc,
   output logic                          en_if_id,
   output logic                          en_id_ex,
   output logic                          en_ex_mem,
   output logic                          en_mem_wb,
   output logic                          flush_if_id,
   output logic                          bubble_id_ex,
   output logic                          bubble_ex_mem,
   output logic                          busy,
   output logic                          dbgState,
   output logic [$clog2(MUL_CYCLES)-1:0] dbgCnt
);

   localparam int CNT_W = $clog2(MUL_CYCLES);
   // The mul_start cycle and the final cnt==0 cycle are both part of the occupancy.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 2);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   ctrl_state_t      state, nextState;
   logic [CNT_W-1:0] cnt, cntNext;
   logic             lu;

   load_use_detect uLoadUse (
      .ex_is_load (ex_is_load),
      .ex_rd      (ex_rd),
      .id_rs_a    (id_rs_a),
      .id_rs_b    (id_rs_b),
      .lu         (lu)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RUN;
         cnt   <= '0;
      end else begin
         state <= nextState;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      en_pc         = 1'b1;
      en_if_id      = 1'b1;
      en_id_ex      = 1'b1;
      en_ex_mem     = 1'b1;
      en_mem_wb     = 1'b1;
      flush_if_id   = 1'b0;
      bubble_id_ex  = 1'b0;
      bubble_ex_mem = 1'b0;
      nextState     = state;
      cntNext       = cnt;

      // A frozen pipeline also freezes the sequencer, so stalled cycles never count.
      if (!reset || mem_stall) begin
         en_pc     = 1'b0;
         en_if_id  = 1'b0;
         en_id_ex  = 1'b0;
         en_ex_mem = 1'b0;
         en_mem_wb = 1'b0;
      end else begin
         case (state)
            RUN: begin
               if (mul_start) begin
                  en_pc         = 1'b0;
                  en_if_id      = 1'b0;
                  en_id_ex      = 1'b0;
                  bubble_ex_mem = 1'b1;
                  nextState     = MUL_WAIT;
                  cntNext       = CNT_LOAD;
               end else if (lu) begin
                  // The branch is not flushed here; it re-resolves once the bubble passes.
                  en_pc        = 1'b0;
                  en_if_id     = 1'b0;
                  bubble_id_ex = 1'b1;
               end else if (br_taken) begin
                  flush_if_id = 1'b1;
               end
            end
            MUL_WAIT: begin
               if (cnt != '0) begin
                  en_pc         = 1'b0;
                  en_if_id      = 1'b0;
                  en_id_ex      = 1'b0;
                  bubble_ex_mem = 1'b1;
                  cntNext       = cnt - CNT_ONE;
               end else begin
                  nextState = RUN;
               end
            end
            default: nextState = RUN;
         endcase
      end
   end

   assign busy     = reset && ((state == MUL_WAIT) || (mul_start && !mem_stall));
   assign dbgState = (state == MUL_WAIT);
   assign dbgCnt   = cnt;

endmodule
